// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and filters ps2_clk, deserializes 11-bit
// frames with odd parity, and folds set-2 E0/F0 prefixes into single key events.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER  = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_error,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       key_strobe
);

    localparam int unsigned FW = 4;
    localparam int unsigned TW = 16;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_filt, clk_filt_d, sample;
    logic [FW-1:0] filt_cnt;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          ext_pend, brk_pend;

    // Two-stage synchronizers for both asynchronous PS/2 lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter on ps2_clk; sample pulse follows a filtered falling edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
            sample     <= 1'b0;
        end else begin
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FILT_LAST) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
            clk_filt_d <= clk_filt;
            sample     <= clk_filt_d & ~clk_filt;
        end
    end

    // Frame deserializer with inter-bit timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            if (state == ST_IDLE) begin
                to_cnt <= '0;
                if (sample && !data_s2) begin
                    state   <= ST_DATA;
                    bit_cnt <= '0;
                end
            end else if (sample) begin
                to_cnt <= '0;
                case (state)
                    ST_DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= data_s2;
                        state   <= ST_STOP;
                    end
                    default: begin
                        if (data_s2 && (^{shift, par_bit})) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (to_cnt == TO_LAST) begin
                state       <= ST_IDLE;
                frame_error <= 1'b1;
                to_cnt      <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Set-2 prefix decoder; status bytes are passed on rx_byte only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
            key_code     <= '0;
            key_extended <= 1'b0;
            key_released <= 1'b0;
            key_strobe   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (frame_error) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (rx_valid) begin
                case (rx_byte)
                    8'hE0: ext_pend <= 1'b1;
                    8'hF0: brk_pend <= 1'b1;
                    8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                    default: begin
                        key_code     <= rx_byte;
                        key_extended <= ext_pend;
                        key_released <= brk_pend;
                        key_strobe   <= 1'b1;
                        ext_pend     <= 1'b0;
                        brk_pend     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed protocol cases plus random
// frames, scored against a byte/key-event level reference model.
module tb_ps2_keyboard_rx;

    localparam int unsigned FILTER  = 4;
    localparam int unsigned TIMEOUT = 4096;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_byte, key_code;
    logic       rx_valid, frame_error, key_extended, key_released, key_strobe;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int key_cyc = 0;
    int hp = 20;

    logic [7:0] got_rx[$];
    logic [7:0] exp_rx[$];
    key_t       got_keys[$];
    key_t       exp_keys[$];
    int         got_err = 0;
    int         exp_err = 0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;

    ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_error(frame_error),
        .key_code(key_code), .key_extended(key_extended),
        .key_released(key_released), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collect DUT events away from the active edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                got_rx.push_back(rx_byte);
                rx_cyc = cyc;
            end
            if (frame_error) got_err++;
            if (key_strobe) begin
                got_keys.push_back({key_code, key_extended, key_released});
                key_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what a correct receiver reports for each frame
    task automatic model_byte(input logic [7:0] b);
        exp_rx.push_back(b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            exp_keys.push_back({b, m_ext, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_error();
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (hp) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (hp) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_tail(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
    endtask

    task automatic tx(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        send_tail(b, bad_par, bad_stop);
        if (bad_par || bad_stop) model_error();
        else model_byte(b);
    endtask

    task automatic compare_step(input string tag);
        int n;
        repeat (12) @(negedge clk);
        check({tag, ":rx_count"}, got_rx.size(), exp_rx.size());
        n = (got_rx.size() < exp_rx.size()) ? got_rx.size() : exp_rx.size();
        for (int i = 0; i < n; i++) check({tag, ":rx_byte"}, got_rx[i], exp_rx[i]);
        check({tag, ":key_count"}, got_keys.size(), exp_keys.size());
        n = (got_keys.size() < exp_keys.size()) ? got_keys.size() : exp_keys.size();
        for (int i = 0; i < n; i++) begin
            check({tag, ":key_code"}, got_keys[i].code, exp_keys[i].code);
            check({tag, ":key_ext"}, got_keys[i].ext, exp_keys[i].ext);
            check({tag, ":key_rel"}, got_keys[i].rel, exp_keys[i].rel);
        end
        check({tag, ":frame_err"}, got_err, exp_err);
        got_rx.delete(); exp_rx.delete(); got_keys.delete(); exp_keys.delete();
        got_err = 0;
        exp_err = 0;
    endtask

    task automatic glitch(input int len);
        @(negedge clk) ps2_clk = 1'b0;
        repeat (len) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int r;
        repeat (5) @(negedge clk);
        check("reset:rx_byte", rx_byte, 8'h00);
        check("reset:key_code", key_code, 8'h00);
        check("reset:pulses", {rx_valid, frame_error, key_strobe}, 3'b000);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        tx(8'h1C, 1'b0, 1'b0);
        compare_step("make_1c");
        check("latency:rx_to_key", key_cyc - rx_cyc, 1);
        check("hold:key_code", key_code, 8'h1C);

        tx(8'hF0, 1'b0, 1'b0); tx(8'h1C, 1'b0, 1'b0);
        compare_step("break_1c");
        tx(8'hE0, 1'b0, 1'b0); tx(8'hF0, 1'b0, 1'b0); tx(8'h75, 1'b0, 1'b0);
        compare_step("ext_break_75");
        tx(8'h75, 1'b0, 1'b0);
        compare_step("plain_75");

        tx(8'h1C, 1'b1, 1'b0); tx(8'h1C, 1'b0, 1'b0);
        compare_step("bad_parity");
        tx(8'h1C, 1'b0, 1'b1); tx(8'h1C, 1'b0, 1'b0);
        compare_step("bad_stop");

        tx(8'hE0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(negedge clk);
        model_error();
        compare_step("timeout");
        tx(8'h6B, 1'b0, 1'b0);
        compare_step("after_timeout");

        @(negedge clk) ps2_data = 1'b0;
        glitch(FILTER - 1);
        repeat (30) @(negedge clk);
        ps2_data = 1'b1;
        compare_step("short_glitch");
        tx(8'h3A, 1'b0, 1'b0);
        compare_step("after_short_glitch");
        @(negedge clk) ps2_data = 1'b0;
        glitch(FILTER);
        send_tail(8'h5A, 1'b0, 1'b0);
        model_byte(8'h5A);
        compare_step("long_glitch_start");

        tx(8'hFA, 1'b0, 1'b0); tx(8'hAA, 1'b0, 1'b0);
        compare_step("status_bytes");

        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset:outputs", {rx_byte, key_code, key_extended, key_released},
              18'h0);
        check("midreset:pulses", {rx_valid, frame_error, key_strobe}, 3'b000);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(negedge clk);
        got_rx.delete(); exp_rx.delete(); got_keys.delete(); exp_keys.delete();
        got_err = 0; exp_err = 0; m_ext = 1'b0; m_brk = 1'b0;
        tx(8'h29, 1'b0, 1'b0);
        compare_step("after_reset");

        for (int f = 0; f < 30; f++) begin
            hp = $urandom_range(20, 32);
            r = $urandom_range(0, 99);
            if (r < 20) b = 8'hE0;
            else if (r < 40) b = 8'hF0;
            else if (r < 48) b = 8'hAA;
            else b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            tx(b, r < 10, r >= 10 && r < 15);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            if (f % 3 == 2) compare_step("random");
        end
        compare_step("random_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
